// File: rtl/water_dispense_sequencer_pkg.sv
// Shared types and default constants for the water dispense sequencer.
// The optional pause feature is enabled by defining WATER_DISPENSE_PAUSE_EN.
package water_dispenser_pkg;

  localparam int DEFAULT_TIME_WIDTH       = 16;
  localparam int DEFAULT_TICKS_PER_SECOND = 1000;
  localparam int DEFAULT_PRIME_CYCLES     = 50;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_DISPENSE,
    ST_PAUSED,
    ST_DONE
  } state_t;

  // Counter width that stays at least one bit for tiny terminal counts.
  function automatic int cnt_width(input int terminal);
    return (terminal <= 1) ? 1 : $clog2(terminal);
  endfunction

endpackage

// File: rtl/water_dispense_sequencer_if.sv
// Control/status bundle between a dispenser controller and the sequencer.
// The pause line is only honoured when WATER_DISPENSE_PAUSE_EN is defined.
interface water_dispense_sequencer_if #(
  parameter int TIME_WIDTH = water_dispenser_pkg::DEFAULT_TIME_WIDTH
) ();

  logic                  start;
  logic [TIME_WIDTH-1:0] start_time;
  logic                  cancel;
  logic                  pause;
  logic                  pump_on;
  logic                  valve_open;
  logic                  busy;
  logic                  done;
  logic                  aborted;
  logic [TIME_WIDTH-1:0] remaining_time;

  modport master (
    output start, start_time, cancel, pause,
    input  pump_on, valve_open, busy, done, aborted, remaining_time
  );

  modport slave (
    input  start, start_time, cancel, pause,
    output pump_on, valve_open, busy, done, aborted, remaining_time
  );

endinterface

// File: rtl/water_dispense_sequencer_prescaler.sv
// Divides the clock down to a one-cycle tick every TICKS_PER_SECOND enabled cycles.
// Holding enable low freezes the count; clear restarts it from zero.
module second_tick_prescaler
  import water_dispenser_pkg::*;
#(
  parameter int TICKS_PER_SECOND = DEFAULT_TICKS_PER_SECOND
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_width(TICKS_PER_SECOND);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SECOND - 1);

  logic [CW-1:0] r_count;

  assign tick = enable && (r_count == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/water_dispense_sequencer.sv
// Pump/valve sequencer: prime the pump, dispense for N seconds, then signal done.
// Define WATER_DISPENSE_PAUSE_EN to let the pause input hold a dispense mid-second.
module water_dispense_sequencer
  import water_dispenser_pkg::*;
#(
  parameter int TIME_WIDTH       = DEFAULT_TIME_WIDTH,
  parameter int TICKS_PER_SECOND = DEFAULT_TICKS_PER_SECOND,
  parameter int PRIME_CYCLES     = DEFAULT_PRIME_CYCLES
) (
  input logic                       clock,
  input logic                       reset,
  water_dispense_sequencer_if.slave bus
);

  localparam int PW = cnt_width(PRIME_CYCLES);
  localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [TIME_WIDTH-1:0] r_remaining;
  logic [TIME_WIDTH-1:0] w_remaining_next;
  logic [PW-1:0]         r_prime_cnt;
  logic [PW-1:0]         w_prime_cnt_next;
  logic                  r_aborted;
  logic                  w_aborted_next;
  logic                  w_tick;
  logic                  w_pause_req;
  logic                  w_ps_enable;
  logic                  w_ps_clear;

`ifdef WATER_DISPENSE_PAUSE_EN
  assign w_pause_req = bus.pause;
`else
  assign w_pause_req = bus.pause & 1'b0;
`endif

  // Prescaler runs only while dispensing, holds its count while paused.
  assign w_ps_enable = (r_state == ST_DISPENSE);
  assign w_ps_clear  = (r_state != ST_DISPENSE) && (r_state != ST_PAUSED);

  second_tick_prescaler #(
    .TICKS_PER_SECOND(TICKS_PER_SECOND)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .enable(w_ps_enable),
    .clear (w_ps_clear),
    .tick  (w_tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_prime_cnt <= '0;
      r_aborted   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      r_prime_cnt <= w_prime_cnt_next;
      r_aborted   <= w_aborted_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_prime_cnt_next = '0;
    w_aborted_next   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.cancel) begin
          if (bus.start_time != '0) begin
            w_state_next     = ST_PRIME;
            w_remaining_next = bus.start_time;
          end else begin
            w_state_next = ST_DONE;
          end
        end
      end

      ST_PRIME: begin
        if (bus.cancel) begin
          w_state_next     = ST_IDLE;
          w_remaining_next = '0;
          w_aborted_next   = 1'b1;
        end else if (r_prime_cnt == PRIME_LAST) begin
          w_state_next = ST_DISPENSE;
        end else begin
          w_prime_cnt_next = r_prime_cnt + PW'(1);
        end
      end

      ST_DISPENSE: begin
        if (bus.cancel) begin
          w_state_next     = ST_IDLE;
          w_remaining_next = '0;
          w_aborted_next   = 1'b1;
        end else if (w_tick && (r_remaining <= TIME_WIDTH'(1))) begin
          w_state_next     = ST_DONE;
          w_remaining_next = '0;
        end else begin
          if (w_tick) begin
            w_remaining_next = r_remaining - TIME_WIDTH'(1);
          end
          if (w_pause_req) begin
            w_state_next = ST_PAUSED;
          end
        end
      end

      ST_PAUSED: begin
        if (bus.cancel) begin
          w_state_next     = ST_IDLE;
          w_remaining_next = '0;
          w_aborted_next   = 1'b1;
        end else if (!w_pause_req) begin
          w_state_next = ST_DISPENSE;
        end
      end

      ST_DONE: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next     = ST_IDLE;
        w_remaining_next = '0;
      end
    endcase
  end

  assign bus.busy           = (r_state != ST_IDLE);
  assign bus.pump_on        = (r_state == ST_PRIME) || (r_state == ST_DISPENSE) || (r_state == ST_PAUSED);
  assign bus.valve_open     = (r_state == ST_DISPENSE);
  assign bus.done           = (r_state == ST_DONE);
  assign bus.aborted        = r_aborted;
  assign bus.remaining_time = r_remaining;

endmodule
